lbr_unit: RTL

Last-branch-record (LBR) unit: the responder for the `lbrReq` commands the control unit raises on `RDLBR` (2'b10) and `WRLBR` (2'b11). It keeps a circular history of the most recent taken branches and jumps as from-PC/to-PC pairs, answers indexed reads one cycle after acceptance, and takes control writes (enable, clear). It sits beside the execute/writeback path: records arrive from branch resolution, and read data returns on the `memtoReg` = 2'b10 writeback leg.

---
 rtl/lbr_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lbr_unit.sv
// Last-branch-record unit: circular from/to PC history with indexed reads and an
// enable/clear control write that walks the array back to zero.
//
// state   | meaning
// S_IDLE  | accepting reads/writes, recording branches when enabled
// S_CLEAR | zeroing one entry per cycle via clr_ptr, requests held off
module lbr_unit #(
    parameter int CORE         = 0,
    parameter int ADDRESS_BITS = 32,
    parameter int DEPTH        = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      branch_valid,
    input  logic [ADDRESS_BITS-1:0]   branch_from_pc,
    input  logic [ADDRESS_BITS-1:0]   branch_to_pc,
    input  logic [1:0]                lbr_req,
    input  logic [ADDRESS_BITS-1:0]   lbr_index,
    input  logic [ADDRESS_BITS-1:0]   lbr_wdata,
    output logic                      lbr_ready,
    output logic                      lbr_rvalid,
    output logic [ADDRESS_BITS-1:0]   lbr_rdata,
    output logic                      lbr_enable,
    output logic [$clog2(DEPTH):0]    lbr_count,
    input  logic                      report
);

    localparam int          IW   = $clog2(DEPTH);
    localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [IW-1:0]            head;
    logic [IW-1:0]            clr_ptr;
    logic [IW-1:0]            age;
    logic [IW-1:0]            slot;
    logic [ADDRESS_BITS-1:0]  from_mem [DEPTH];
    logic [ADDRESS_BITS-1:0]  to_mem   [DEPTH];
    logic                     rd_accept;
    logic                     wr_accept;
    logic                     wr_clear;
    logic                     rec;
    logic [ADDRESS_BITS-1:0]  rd_sel;

    // The cycle-by-cycle print is left to the simulation wrapper; report and the
    // ignored index/wdata bits are only folded here so they count as consumed.
    logic unused_bits;
    assign unused_bits = ^{report, lbr_index[ADDRESS_BITS-1:IW+1],
                           lbr_wdata[ADDRESS_BITS-1:2], 32'(CORE)};

    assign age  = lbr_index[IW:1];
    assign slot = head - IW'(1) - age;

    always_comb begin
        next_state = state;
        lbr_ready  = 1'b0;
        rd_accept  = 1'b0;
        wr_accept  = 1'b0;
        wr_clear   = 1'b0;
        rec        = 1'b0;
        case (state)
            S_IDLE: begin
                lbr_ready = 1'b1;
                rd_accept = (lbr_req == 2'b10);
                wr_accept = (lbr_req == 2'b11);
                wr_clear  = wr_accept & lbr_wdata[1];
                // Old enable gates the branch; a clearing write drops it.
                rec       = branch_valid & lbr_enable & ~wr_clear;
                if (wr_clear) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_ptr == IW'(DEPTH - 1)) begin
                    next_state = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rd_sel = '0;
        if ({1'b0, age} < lbr_count) begin
            rd_sel = lbr_index[0] ? to_mem[slot] : from_mem[slot];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            head       <= '0;
            clr_ptr    <= '0;
            lbr_count  <= '0;
            lbr_enable <= 1'b0;
            lbr_rvalid <= 1'b0;
            lbr_rdata  <= '0;
        end else begin
            state      <= next_state;
            lbr_rvalid <= rd_accept;
            if (rd_accept) begin
                lbr_rdata <= rd_sel;
            end
            if (rec) begin
                head <= head + IW'(1);
                if (lbr_count != FULL) begin
                    lbr_count <= lbr_count + (IW+1)'(1);
                end
            end
            if (wr_accept) begin
                lbr_enable <= lbr_wdata[0];
            end
            if (wr_clear) begin
                head      <= '0;
                lbr_count <= '0;
                clr_ptr   <= '0;
            end else if (state == S_CLEAR) begin
                clr_ptr <= clr_ptr + IW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                from_mem[i] <= '0;
                to_mem[i]   <= '0;
            end
        end else if (rec) begin
            from_mem[head] <= branch_from_pc;
            to_mem[head]   <= branch_to_pc;
        end else if (state == S_CLEAR) begin
            from_mem[clr_ptr] <= '0;
            to_mem[clr_ptr]   <= '0;
        end
    end

endmodule
